muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: ITER_CYCLES, 32, number of iteration cycles for multiply and divide; fixed at 32, any other value unsupported.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  CPU presents an HI/LO operation this cycle.
REQ-005 op_code  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
REQ-006 op_a  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 op_b  input  32  rt operand: multiplier or divisor.
REQ-008 cancel  input  1  CP0 exception flush; aborts any in-flight multiply or divide.
REQ-009 busy  output  1  iterative operation in progress; CPU stalls MFHI/MFLO and new ops.
REQ-010 done  output  1  one-cycle pulse when a multiply or divide result has been committed.
REQ-011 hi_out  output  32  current HI register, feeds the MFHI path.
REQ-012 lo_out  output  32  current LO register, feeds the MFLO path.

Function
REQ-013 The unit SHALL accept an op on a rising edge where op_valid=1, busy=0 and cancel=0; op_valid while busy=1 SHALL be ignored.
REQ-014 MTHI/MTLO SHALL write op_a to HI/LO on the accepting edge, with busy and done unaffected and the new value visible the next cycle.
REQ-015 Reserved op_code values SHALL be ignored with no state change.
REQ-016 The state machine SHALL have states IDLE, CALC and FIX: IDLE->CALC on accepting a MULT/MULTU/DIV/DIVU; CALC for exactly 32 cycles; CALC->FIX; FIX->IDLE.
REQ-017 busy SHALL be 1 in CALC and FIX (33 cycles) and 0 in IDLE.
REQ-018 HI/LO SHALL be written on the FIX->IDLE edge, and done SHALL be 1 for the single following cycle.
REQ-019 Operands SHALL be latched on acceptance; op_a/op_b changes during CALC SHALL have no effect.
REQ-020 Multiply SHALL use radix-2 shift-add on magnitudes, with FIX applying two's-complement negation for signed operands of differing sign, yielding {HI,LO} = full 64-bit product.
REQ-021 Divide SHALL use restoring division on magnitudes, with FIX applying signs: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
REQ-022 Divide by zero (op_b=0) SHALL produce HI=op_a and LO=32'hFFFFFFFF for both DIV and DIVU, with normal latency.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce LO=32'h80000000 and HI=0.
REQ-024 hi_out/lo_out SHALL hold previous values throughout CALC and FIX.
REQ-025 cancel=1 in CALC or FIX SHALL return the unit to IDLE on that edge with HI/LO unchanged and no done pulse.
REQ-026 cancel=1 together with op_valid in IDLE SHALL suppress acceptance, including MTHI/MTLO.

Reset
REQ-027 rst=1 SHALL force the state to IDLE, HI=0, LO=0, busy=0 and done=0 on the next edge, overriding op_valid and cancel.
REQ-028 Reset asserted mid-operation SHALL discard the operation without a done pulse.

Structure
REQ-029 Package muldiv_pkg SHALL hold the op_code constants, the state encoding and the ITER_CYCLES constant.
REQ-030 The 32-step datapath (shift-add / restoring subtract, 64-bit accumulator, 5-bit step counter) SHALL be one sub-module, muldiv_iter, with the FSM, sign fix and HI/LO held in muldiv_unit.

Verification
REQ-031 MULTU: op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF -> busy=1 for 33 cycles, then HI=32'hFFFFFFFE, LO=32'h00000001, done=1 for one cycle.
REQ-032 MULT: op_a=-3, op_b=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-033 DIV: op_a=-7, op_b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU: op_a=5, op_b=0 -> HI=5, LO=32'hFFFFFFFF.
REQ-034 MTHI with op_a=32'h1234 -> hi_out=32'h1234 on the next cycle, busy stays 0; a second op_valid issued 10 cycles into a DIV is ignored.
REQ-035 cancel pulsed 5 cycles into a MULT with HI=LO=32'hA5A5A5A5 -> busy=0 the next cycle, HI/LO stay 32'hA5A5A5A5, no done.
REQ-036 rst asserted mid-DIV -> HI=LO=0, busy=0, done=0; a new MULTU 2*3 then gives LO=6, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, op codes and FSM encoding for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned ITER_CYCLES = 32;
   localparam int unsigned CNT_W       = $clog2(ITER_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   // Absolute value for signed ops; unsigned ops pass through untouched.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic is_signed);
      return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// 32-step unsigned datapath: radix-2 shift-add multiply or restoring divide.
// acc holds {HI-half, LO-half}: product, or {remainder, quotient}.
module muldiv_iter
   import muldiv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_div,
   input  logic              step,
   input  logic [XLEN-1:0]   mag_a,
   input  logic [XLEN-1:0]   mag_b,
   output logic [2*XLEN-1:0] acc,
   output logic              last_c
);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic              div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     trial;

   always_comb begin
      acc_d   = acc_q;
      opb_d   = opb_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
      // Shifted partial remainder minus divisor; bit XLEN set means borrow (restore).
      trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
      if (start) begin
         acc_d = {XLEN'(0), mag_a};
         opb_d = mag_b;
         div_d = is_div;
         cnt_d = '0;
      end else if (step) begin
         if (div_q) begin
            if (!trial[XLEN]) acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else              acc_d = {acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], 1'b0};
         end else begin
            acc_d = {add_sum, acc_q[XLEN-1:1]};
         end
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         opb_q <= opb_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc    = acc_q;
   assign last_c = (cnt_q == CNT_W'(ITER_CYCLES - 1));

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: control FSM, sign fix-up and architectural HI/LO.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic              div0_q, div0_d;
   logic              accept_c, start_c, signed_c, is_div_c;
   logic [XLEN-1:0]   mag_a_c, mag_b_c, quo_c, rem_c;
   logic [2*XLEN-1:0] acc, prod_c;
   logic              last_c;

   assign accept_c = op_valid && (state_q == IDLE) && !cancel;
   assign signed_c = (op_code == OP_MULT) || (op_code == OP_DIV);
   assign is_div_c = (op_code == OP_DIV) || (op_code == OP_DIVU);
   assign start_c  = accept_c && (op_code == OP_MULT || op_code == OP_MULTU || is_div_c);
   assign mag_a_c  = magnitude(op_a, signed_c);
   assign mag_b_c  = magnitude(op_b, signed_c);

   muldiv_iter u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start_c),
      .is_div (is_div_c),
      .step   (state_q == CALC),
      .mag_a  (mag_a_c),
      .mag_b  (mag_b_c),
      .acc    (acc),
      .last_c (last_c)
   );

   // Sign restoration applied to the unsigned datapath result.
   assign prod_c = neg_res_q ? (2*XLEN)'(-acc) : acc;
   assign quo_c  = neg_res_q ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
   assign rem_c  = neg_rem_q ? XLEN'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      a_d       = a_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (op_code == OP_MTHI) hi_d = op_a;
               if (op_code == OP_MTLO) lo_d = op_a;
               if (start_c) begin
                  state_d   = CALC;
                  a_d       = op_a;
                  is_div_d  = is_div_c;
                  neg_res_d = signed_c && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                  neg_rem_d = signed_c && op_a[XLEN-1];
                  div0_d    = (op_b == '0);
               end
            end
         end
         CALC: begin
            if (cancel)      state_d = IDLE;
            else if (last_c) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_c;
               end else if (div0_q) begin
                  hi_d = a_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_c;
                  lo_d = quo_c;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         a_q       <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         a_q       <= a_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule
